secded_check_pipe: RTL and testbench
====================================

// Module: secded_check_pipe
// PURPOSE
//  Parametrised, pipelined SEC-DED (extended Hamming) checker/corrector for a DATA_W-bit word plus its check bits.
//  Generalises the fixed 16-bit combinational error-correction benchmark: configurable width, detect-only mode,
//  valid/ready flow control, and saturating error-statistics counters. Sits on memory/link read paths.
// PARAMETERS
//  DATA_W   16  data bits per word (>=4)
//  CNT_W    16  width of each error counter
//  R (local)    smallest r with 2**r >= DATA_W+r+1 (5 for 16); CHK_W = R+1 (extra bit = overall parity)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        input word valid
//  in_ready   out  1        block can accept input this cycle
//  in_data    in   DATA_W   received data
//  in_chk     in   CHK_W    received check bits; [R-1:0] Hamming, [R] overall parity
//  corr_en    in   1        1: correct single errors; 0: detect only (data passes raw); sampled with the word
//  out_valid  out  1        output word valid
//  out_ready  in   1        downstream accepts
//  out_data   out  DATA_W   corrected (or raw) data
//  out_sec    out  1        single error detected (corrected if corr_en)
//  out_ded    out  1        uncorrectable error detected
//  clr_cnt    in   1        synchronous clear of both counters
//  sec_cnt    out  CNT_W    count of accepted-out words with out_sec
//  ded_cnt    out  CNT_W    count of accepted-out words with out_ded
// BEHAVIOUR
//  - Reset: out_valid=0, internal stage valid=0, out_data/out_sec/out_ded=0, sec_cnt=ded_cnt=0. In-flight words
//    are discarded when rst asserts mid-operation; in_ready=1 in the first cycle after reset releases.
//  - Layout: data occupies Hamming positions 1..DATA_W+R that are not powers of two, in ascending bit order;
//    check bit k covers positions with bit k set; overall parity = XOR of all data and Hamming check bits.
//  - Stage 1 (registered): syndrome s[R-1:0] and overall mismatch p, data and corr_en carried along.
//  - Stage 2 (registered): classification and correction:
//      s==0,p==0 -> clean; sec=0, ded=0
//      p==1, s==0 -> overall parity bit in error; sec=1, data unchanged
//      p==1, s is a check position -> sec=1, data unchanged
//      p==1, s maps to a data position -> sec=1; that data bit flipped iff corr_en
//      p==1, s > DATA_W+R (non-existent position) -> ded=1, data raw
//      s!=0, p==0 -> ded=1, data raw
//    sec and ded are never both 1.
//  - Latency 2 cycles from input accept (in_valid&in_ready) to out_valid, with no stalls.
//  - Flow control: each stage advances when its output register is empty or consumed; in_ready =
//    !stage1_valid || stage1_advances (combinational from out_ready; no other comb in->out paths).
//    Full throughput of 1 word/cycle; no word is lost or duplicated under any out_ready pattern.
//  - out_* held stable while out_valid && !out_ready.
//  - Counters: increment on out_valid&&out_ready with matching flag; saturate at all-ones (no wrap);
//    clr_cnt has priority over a same-cycle increment (result 0).
// STRUCTURE
//  - secded_pkg: function secded_r(DATA_W), function secded_pos(data index)->position, function
//    secded_encode(data)->CHK_W check bits (shared with the bench's reference model).
//  - One sub-module: secded_syndrome (combinational: data+chk -> s, p). Pipeline and counters live in the top.
// TESTING (DATA_W=16, CHK_W=6 unless stated)
//  1 in_data=16'hA5A5, in_chk=secded_encode(16'hA5A5), out_ready=1 -> 2 cycles later out_data=16'hA5A5, sec=0, ded=0.
//  2 Same word with data bit 3 flipped, corr_en=1 -> out_data=16'hA5A5, sec=1, sec_cnt=1; corr_en=0 -> out_data=16'hA5AD, sec=1.
//  3 Data bits 3 and 7 flipped -> ded=1, sec=0, out_data=16'hA52D raw, ded_cnt increments by 1; chk[5] alone flipped -> sec=1, data intact.
//  4 Stream 8 words back-to-back, out_ready=0 for cycles 3-5 -> in_ready drops once both stages are full,
//    all 8 words emerge in order, none lost or duplicated.
//  5 CNT_W=2: 5 single-error words -> sec_cnt saturates at 3; clr_cnt coincident with a 6th sec word -> sec_cnt=0.
//  6 Assert rst with 2 words in flight -> out_valid=0 immediately, counters 0, no stale word emitted after release.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared SEC-DED helpers: check-bit count, data-to-position map, coverage masks and
// a reference encoder. All functions are elaboration-safe constant functions.
package secded_pkg;

    localparam int SECDED_MAX_DW = 64;
    localparam int SECDED_MAX_CW = 8;

    function automatic int secded_r(input int dw);
        int r;
        r = 0;
        for (int k = SECDED_MAX_CW - 2; k >= 1; k--)
            if ((1 << k) >= dw + k + 1) r = k;
        return r;
    endfunction

    // Hamming position of data bit idx: the idx-th position that is not a power of two
    function automatic int secded_pos(input int idx);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int p = 3; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx && res == 0) res = p;
                n++;
            end
        end
        return res;
    endfunction

    function automatic logic [SECDED_MAX_DW-1:0] secded_mask(input int k, input int dw);
        logic [SECDED_MAX_DW-1:0] m;
        int pos;
        m = '0;
        for (int i = 0; i < SECDED_MAX_DW; i++) begin
            if (i < dw) begin
                pos = secded_pos(i);
                if (((pos >> k) & 1) != 0) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [SECDED_MAX_CW-1:0] secded_encode(
        input logic [SECDED_MAX_DW-1:0] data,
        input int                       dw
    );
        logic [SECDED_MAX_CW-1:0] c;
        logic par;
        int   r;
        int   pos;
        r   = secded_r(dw);
        c   = '0;
        par = 1'b0;
        for (int i = 0; i < SECDED_MAX_DW; i++) begin
            if (i < dw) begin
                pos = secded_pos(i);
                par ^= data[i];
                for (int k = 0; k < SECDED_MAX_CW - 1; k++)
                    if (k < r && ((pos >> k) & 1) != 0) c[k] ^= data[i];
            end
        end
        par ^= ^c;
        c[r] = par;
        return c;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome/overall-parity generator for an extended Hamming codeword.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int DATA_W = 16,
    localparam int R     = secded_r(DATA_W),
    localparam int CHK_W = R + 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [R-1:0]      s,
    output logic              p
);

    for (genvar k = 0; k < R; k++) begin : g_syn
        localparam logic [SECDED_MAX_DW-1:0] MASK = secded_mask(k, DATA_W);
        assign s[k] = chk[k] ^ (^(data & MASK[DATA_W-1:0]));
    end

    // all received bits, overall parity included, must XOR to zero when clean
    assign p = ^{data, chk};

endmodule

// File: rtl/secded_check_pipe.sv
// Two-stage pipelined SEC-DED checker/corrector with valid/ready flow control
// and saturating single/double error counters.
module secded_check_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    localparam int R     = secded_r(DATA_W),
    localparam int CHK_W = R + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam int STAGES = 2;
    localparam logic [R:0] NPOS = (R+1)'(DATA_W + R);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [R-1:0]      s;
        logic              p;
        logic              corr_en;
    } st1_t;

    logic [STAGES:1]   vld_pipe;
    st1_t              st1;
    logic [R-1:0]      syn_s;
    logic              syn_p;
    logic              adv2;
    logic [DATA_W-1:0] hit;
    logic [DATA_W-1:0] data_n;
    logic              sec_n;
    logic              ded_n;

    secded_syndrome #(.DATA_W(DATA_W)) u_syn (
        .data (in_data),
        .chk  (in_chk),
        .s    (syn_s),
        .p    (syn_p)
    );

    assign out_valid = vld_pipe[2];
    assign adv2      = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready  = !vld_pipe[1] || adv2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            st1         <= '0;
        end else if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) st1 <= '{data: in_data, s: syn_s, p: syn_p, corr_en: corr_en};
        end
    end

    // one-hot flip vector: bit i set when the syndrome names data bit i
    for (genvar i = 0; i < DATA_W; i++) begin : g_hit
        localparam int P = secded_pos(i);
        assign hit[i] = (st1.s == P[R-1:0]);
    end

    always_comb begin
        data_n = st1.data;
        sec_n  = 1'b0;
        ded_n  = 1'b0;
        if (st1.p) begin
            if ({1'b0, st1.s} > NPOS) begin
                ded_n = 1'b1;
            end else begin
                sec_n = 1'b1;
                if (st1.corr_en) data_n = st1.data ^ hit;
            end
        end else if (st1.s != '0) begin
            ded_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            out_data    <= '0;
            out_sec     <= 1'b0;
            out_ded     <= 1'b0;
        end else if (!vld_pipe[2] || out_ready) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                out_data <= data_n;
                out_sec  <= sec_n;
                out_ded  <= ded_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (clr_cnt) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sec && sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
            if (out_ded && ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_secded_check_pipe.sv
// Directed bench for secded_check_pipe: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_secded_check_pipe;
    import secded_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  in_chk;
    logic        corr_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sec;
    logic        out_ded;
    logic        clr_cnt;
    logic [15:0] sec_cnt;
    logic [15:0] ded_cnt;

    logic        d1_in_ready;
    logic        d1_out_valid;
    logic [15:0] d1_out_data;
    logic        d1_out_sec;
    logic        d1_out_ded;
    logic [1:0]  d1_sec_cnt;
    logic [1:0]  d1_ded_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    secded_check_pipe #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sec(out_sec), .out_ded(out_ded), .clr_cnt(clr_cnt),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    secded_check_pipe #(.DATA_W(16), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready),
        .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
        .out_sec(d1_out_sec), .out_ded(d1_out_ded), .clr_cnt(clr_cnt),
        .sec_cnt(d1_sec_cnt), .ded_cnt(d1_ded_cnt)
    );

    function automatic logic [5:0] enc(input logic [15:0] d);
        logic [SECDED_MAX_CW-1:0] c;
        c = secded_encode({48'h0, d}, 16);
        return c[5:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one word, then leave the pipe idle so it sits at the output
    task automatic send_one(input logic [15:0] d, input logic [5:0] c, input logic ce);
        in_valid  = 1'b1;
        in_data   = d;
        in_chk    = c;
        corr_en   = ce;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = '0;
        corr_en = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if ({out_data, out_sec, out_ded} !== 18'h0) begin errors++; $display("FAIL rst_out_regs: got %h/%b/%b want 0", out_data, out_sec, out_ded); end
        checks++; if ({sec_cnt, ded_cnt} !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0", sec_cnt, ded_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_clean();
        send_one(16'hA5A5, enc(16'hA5A5), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 16'hA5A5) begin errors++; $display("FAIL clean_data: got %h want a5a5", out_data); end
        checks++; if ({out_sec, out_ded} !== 2'b00) begin errors++; $display("FAIL clean_flags: got %b%b want 00", out_sec, out_ded); end
        checks++; if ({d1_out_valid, d1_out_data, d1_out_sec, d1_out_ded} !== {1'b1, 16'hA5A5, 2'b00}) begin
            errors++; $display("FAIL clean_dut1: got %b %h %b%b want 1 a5a5 00", d1_out_valid, d1_out_data, d1_out_sec, d1_out_ded); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_drain: got %b want 0", out_valid); end
        checks++; if ({sec_cnt, ded_cnt} !== 32'h0) begin errors++; $display("FAIL clean_cnt: got %h/%h want 0/0", sec_cnt, ded_cnt); end
    endtask

    task automatic test_single();
        send_one(16'hA5AD, enc(16'hA5A5), 1'b1);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA5A5, 2'b10}) begin
            errors++; $display("FAIL sec_corr: got %h %b%b want a5a5 10", out_data, out_sec, out_ded); end
        step();
        checks++; if (sec_cnt !== 16'd1) begin errors++; $display("FAIL sec_cnt1: got %0d want 1", sec_cnt); end
        send_one(16'hA5AD, enc(16'hA5A5), 1'b0);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA5AD, 2'b10}) begin
            errors++; $display("FAIL sec_detect_only: got %h %b%b want a5ad 10", out_data, out_sec, out_ded); end
        step();
        // highest data bit sits at the last valid position
        send_one(16'h25A5, enc(16'hA5A5), 1'b1);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA5A5, 2'b10}) begin
            errors++; $display("FAIL sec_msb: got %h %b%b want a5a5 10", out_data, out_sec, out_ded); end
        step();
        checks++; if (sec_cnt !== 16'd3) begin errors++; $display("FAIL sec_cnt3: got %0d want 3", sec_cnt); end
    endtask

    task automatic test_double();
        send_one(16'hA52D, enc(16'hA5A5), 1'b1);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA52D, 2'b01}) begin
            errors++; $display("FAIL ded_two_data: got %h %b%b want a52d 01", out_data, out_sec, out_ded); end
        step();
        checks++; if ({sec_cnt, ded_cnt} !== {16'd3, 16'd1}) begin errors++; $display("FAIL ded_cnt1: got %0d/%0d want 3/1", sec_cnt, ded_cnt); end
        send_one(16'hA5A5, enc(16'hA5A5) ^ 6'h20, 1'b1);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA5A5, 2'b10}) begin
            errors++; $display("FAIL sec_parity_bit: got %h %b%b want a5a5 10", out_data, out_sec, out_ded); end
        step();
        // five Hamming bits flipped: syndrome 31 is beyond position 21, p=1
        send_one(16'hA5A5, enc(16'hA5A5) ^ 6'h1F, 1'b1);
        checks++; if ({out_data, out_sec, out_ded} !== {16'hA5A5, 2'b01}) begin
            errors++; $display("FAIL ded_bad_pos: got %h %b%b want a5a5 01", out_data, out_sec, out_ded); end
        step();
        checks++; if ({sec_cnt, ded_cnt} !== {16'd4, 16'd2}) begin errors++; $display("FAIL cnt_after_ded: got %0d/%0d want 4/2", sec_cnt, ded_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [8];
        logic [15:0] held;
        logic        stall_prev;
        logic        acc;
        logic        saw_block;
        int          idx;
        int          nrecv;
        for (int i = 0; i < 8; i++) words[i] = 16'h1000 + 16'(i * 16'h0123);
        idx = 0; nrecv = 0; saw_block = 1'b0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && nrecv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (idx < 8);
            corr_en   = 1'b1;
            if (idx < 8) begin
                in_data = words[idx];
                in_chk  = enc(words[idx]);
            end
            #1;
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (stall_prev) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++; $display("FAIL stream_hold: got %b %h want 1 %h", out_valid, out_data, held); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (nrecv >= 8 || out_data !== words[nrecv]) begin
                    errors++; $display("FAIL stream_order: word %0d got %h want %h", nrecv, out_data, words[nrecv % 8]); end
                nrecv++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            step();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (nrecv !== 8 || idx !== 8) begin errors++; $display("FAIL stream_count: got %0d out/%0d in want 8/8", nrecv, idx); end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL stream_backpressure: in_ready low seen %b want 1", saw_block); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_dup: extra word %h at idle %0d", out_data, i); end
            step();
        end
    endtask

    task automatic test_saturate();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if ({d1_sec_cnt, sec_cnt} !== 18'h0) begin errors++; $display("FAIL sat_clear: got %0d/%0d want 0/0", d1_sec_cnt, sec_cnt); end
        for (int i = 0; i < 5; i++) begin
            send_one(16'hA5AD, enc(16'hA5A5), 1'b1);
            step();
        end
        checks++; if (d1_sec_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", d1_sec_cnt); end
        checks++; if (sec_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d want 5", sec_cnt); end
        send_one(16'hA5AD, enc(16'hA5A5), 1'b1);
        checks++; if ({out_valid, out_sec} !== 2'b11) begin errors++; $display("FAIL sat_6th_word: got %b%b want 11", out_valid, out_sec); end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if ({d1_sec_cnt, sec_cnt} !== 18'h0) begin errors++; $display("FAIL sat_clr_prio: got %0d/%0d want 0/0", d1_sec_cnt, sec_cnt); end
    endtask

    task automatic test_reset_in_flight();
        send_one(16'hA5AD, enc(16'hA5A5), 1'b1);
        step();
        checks++; if (sec_cnt !== 16'd1) begin errors++; $display("FAIL flight_pre_cnt: got %0d want 1", sec_cnt); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234; in_chk = enc(16'h1234);
        step();
        in_data   = 16'h5678; in_chk = enc(16'h5678);
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL flight_full: valid/ready got %b%b want 10", out_valid, in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({out_valid, sec_cnt, ded_cnt} !== 33'h0) begin
            errors++; $display("FAIL flight_rst: got %b %0d %0d want 0 0 0", out_valid, sec_cnt, ded_cnt); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_release_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_stale: word %h emitted cycle %0d", out_data, i); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_saturate();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
